// File: rtl/psram_pkg.sv
// Shared constants, state encoding and frame builder for the SPI-mode PSRAM controllers.
package psram_pkg;
  localparam logic [7:0] CMD_RST_EN = 8'h66;
  localparam logic [7:0] CMD_RST    = 8'h99;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;

  localparam int FRAME_BITS    = 40;
  localparam int CE_GAP_CYCLES = 2;
  localparam int ADDR_BITS     = 23;
  localparam int CNT_W         = $clog2(FRAME_BITS + 1);
  localparam int GAP_W         = 2;
  localparam int RX_FIRST_BIT  = FRAME_BITS - 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Frame layout: command, address bit 23 (always 0 on an 8 MB part), 23-bit address, payload.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic             we,
                                                        input logic [ADDR_BITS-1:0] addr,
                                                        input logic [7:0]       wdata);
    return we ? {CMD_WRITE, 1'b0, addr, wdata} : {CMD_READ, 1'b0, addr, 8'h00};
  endfunction
endpackage

// File: rtl/psram_byte_ctrl_if.sv
// Request/response bus between a host and the single-byte PSRAM controller.
interface psram_byte_ctrl_if;
  import psram_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [ADDR_BITS-1:0] req_addr;
  logic [7:0]           req_wdata;
  logic                 done;
  logic [7:0]           rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, done, rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, done, rdata
  );
endinterface

// File: rtl/psram_sclk_gate.sv
// Glitch-free PSRAM clock: enable captured on the falling edge, then ANDed with the system clock.
module psram_sclk_gate (
  input  logic clk,
  input  logic rst_n,
  input  logic en_req,
  output logic sclk
);
  logic en_q;
  logic en_d;

  always_comb begin
    en_d = en_req;
  end

  // Changing the enable only while clk is low keeps sclk free of runt pulses.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) en_q <= 1'b0;
    else        en_q <= en_d;
  end

  assign sclk = clk & en_q;
endmodule

// File: rtl/psram_byte_ctrl.sv
// Single-byte read/write controller for an SPI-mode PSRAM: one 40-bit frame per request.
module psram_byte_ctrl
  import psram_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_reset_n,
  input  logic             init_done,
  psram_byte_ctrl_if.slave bus,
  output logic             ce_n,
  output logic             sclk,
  output logic             psram_si,
  input  logic             psram_so
);
  state_t                state_q, state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic                  is_read_q, is_read_d;
  logic [7:0]            rx_q, rx_d;
  logic [7:0]            rdata_q, rdata_d;
  logic                  ce_n_q, ce_n_d;
  logic                  done_q, done_d;
  logic                  si_q, si_d;
  logic                  accept;
  logic                  shift_en;

  // Held low while reset is asserted even though the state already reads IDLE.
  assign bus.req_ready = sys_reset_n && init_done && (state_q == ST_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign shift_en      = (state_q == ST_SHIFT) && (bit_cnt_q != CNT_W'(FRAME_BITS));

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    is_read_d = is_read_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;
    ce_n_d    = ce_n_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          frame_d   = build_frame(bus.req_we, bus.req_addr, bus.req_wdata);
          is_read_d = !bus.req_we;
          bit_cnt_d = '0;
          rx_d      = '0;
          ce_n_d    = 1'b0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (shift_en) begin
          frame_d   = {frame_q[FRAME_BITS-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (is_read_q && (bit_cnt_q >= CNT_W'(RX_FIRST_BIT)))
            rx_d = {rx_q[6:0], psram_so};
        end else begin
          ce_n_d  = 1'b1;
          done_d  = 1'b1;
          if (is_read_q) rdata_d = rx_q;
          // The IDLE cycle in which the next handshake forms is the last deselect cycle.
          gap_cnt_d = GAP_W'(CE_GAP_CYCLES - 2);
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_IDLE;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      is_read_q <= 1'b0;
      rx_q      <= '0;
      rdata_q   <= '0;
      ce_n_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      is_read_q <= is_read_d;
      rx_q      <= rx_d;
      rdata_q   <= rdata_d;
      ce_n_q    <= ce_n_d;
      done_q    <= done_d;
    end
  end

  // Serial data launches half a cycle ahead of each sclk rising edge.
  always_comb begin
    si_d = shift_en ? frame_q[FRAME_BITS-1] : 1'b0;
  end

  always_ff @(negedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) si_q <= 1'b0;
    else              si_q <= si_d;
  end

  psram_sclk_gate u_sclk_gate (
    .clk    (sys_clk),
    .rst_n  (sys_reset_n),
    .en_req (shift_en),
    .sclk   (sclk)
  );

  assign ce_n      = ce_n_q;
  assign psram_si  = si_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
endmodule

// File: doc/psram_byte_ctrl.md
PSRAM_BYTE_CTRL -- requirements
Module: psram_byte_ctrl

Interface
REQ-001 Reset sys_reset_n SHALL be asynchronous and active-low; clock sys_clk.
REQ-002 sys_clk  input  1  system clock; all state advances on its rising edge unless stated otherwise.
REQ-003 sys_reset_n  input  1  asynchronous active-low reset.
REQ-004 init_done  input  1  high once the upstream PSRAM reset sequence (0x66, 0x99) is complete; the block accepts no request while low.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  23  byte address (8 MB device).
REQ-009 req_wdata  input  8  write byte.
REQ-010 done  output  1  one-cycle pulse at end of every frame.
REQ-011 rdata  output  8  read byte; valid while done is high after a read, held until the next read's done.
REQ-012 ce_n  output  1  PSRAM chip enable, active-low.
REQ-013 sclk  output  1  PSRAM serial clock, equal to sys_clk gated by a negedge-registered enable.
REQ-014 psram_si  output  1  serial data to PSRAM (SIO0).
REQ-015 psram_so  input  1  serial data from PSRAM (SIO1).

Function
REQ-016 States: IDLE, SHIFT, GAP.
REQ-017 IDLE: req_ready = init_done.
REQ-018 A handshake occurs at the rising edge where req_valid && req_ready are both high (cycle T).
REQ-019 At T the block SHALL latch the request and load a 40-bit frame: {cmd, 1'b0, req_addr, payload}, with cmd = 0x02 and payload = req_wdata for writes, and cmd = 0x03 and payload = 0x00 for reads.
REQ-020 At T the block SHALL drive ce_n = 0 and enter SHIFT.
REQ-021 psram_si SHALL change only on falling edges of sys_clk and present frame bits MSB first; bit k SHALL be stable across sclk rising edge k.
REQ-022 The sclk enable SHALL be registered on the falling edge of sys_clk from the SHIFT condition, so that sclk is glitch-free and low whenever disabled.
REQ-023 Each frame SHALL contain exactly 40 sclk rising edges, coinciding with sys_clk rising edges T+1 through T+40.
REQ-024 Read: psram_so SHALL be sampled on sys_clk rising edges T+33 to T+40 (sclk edges 32 to 39), MSB first, into rdata.
REQ-025 At T+41: ce_n = 1, sclk held low, done = 1 for one cycle, rdata updated for reads, state = GAP.
REQ-026 GAP SHALL hold ce_n high for 2 sys_clk cycles (CE_GAP_CYCLES), then return to IDLE, giving earliest next accept at T+43; throughput is 43 cycles per byte.
REQ-027 req_ready SHALL be 0 in SHIFT and GAP; req_* inputs are ignored there.
REQ-028 If init_done falls during SHIFT or GAP, the current frame SHALL complete normally; no new accept occurs until init_done = 1.
REQ-029 If req_valid is held high across done, the next request SHALL be accepted at T+43 with no idle gap beyond GAP.
REQ-030 Address bit 23 SHALL be sent as 0.
REQ-031 Writes SHALL not modify rdata.

Reset
REQ-032 Asserting sys_reset_n low SHALL force: ce_n = 1, sclk enable = 0 (sclk low), psram_si = 0, req_ready = 0, done = 0, rdata = 0x00, state = IDLE, bit counter = 0.
REQ-033 Reset mid-frame SHALL abandon the frame immediately; no done pulse is produced.

Structure
REQ-034 Shared package psram_pkg SHALL hold: CMD_RST_EN = 0x66, CMD_RST = 0x99, CMD_WRITE = 0x02, CMD_READ = 0x03, FRAME_BITS = 40, CE_GAP_CYCLES = 2, and the state encoding.
REQ-035 One sub-module, psram_sclk_gate, SHALL contain the negedge enable register and the clock AND, so it can be reused by the reset sequencer.

Verification
REQ-036 Write: init_done = 1, write addr 0x012345, data 0xA5 -> si stream 0x02, 0x01, 0x23, 0x45, 0xA5 over 40 sclk edges; ce_n low for exactly 41 cycles; done at T+41.
REQ-037 Read: PSRAM model returns 0x5A at addr 0x7FFFFF -> si carries 0x03, 0x7F, 0xFF, 0xFF; rdata = 0x5A with done at T+41; payload bits on si = 0.
REQ-038 init_done = 0 with req_valid = 1 -> req_ready stays 0, ce_n stays 1, sclk has no edges; raising init_done -> accept on the next edge.
REQ-039 Back-to-back: req_valid held for two writes -> second accept exactly at T+43; ce_n high for exactly 2 cycles between frames.
REQ-040 Reset asserted at sclk edge 20 -> ce_n = 1 and sclk low immediately, no done pulse; a subsequent request produces a full clean 40-edge frame.
